// File: rtl/pe_cube_seq.sv
`default_nettype none
// ============================================================================
// Module  : pe_cube_seq
// Brief   : Step sequencer for a pe_cube array. Replays a stored pattern
//           program over conv blocks and registers the feeder data alongside
//           each step. Define PE_CUBE_SEQ_STALL_CNT_EN to add oStallCnt.
// Revision: 1.0
// ============================================================================
module pe_cube_seq #(
  parameter  int ARRAY_NUM  = 3,
  parameter  int CUBE_NUM   = 3,
  parameter  int STEP_DEPTH = 32,
  localparam int AW         = $clog2(STEP_DEPTH)
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iPrgWe,
  input  logic [AW-1:0]           iPrgAddr,
  input  logic [4*ARRAY_NUM-2:0]  iPrgData,
  input  logic [AW:0]             iNumSteps,
  input  logic [7:0]              iNumBlocks,
  input  logic [AW-1:0]           iClearStep,
  input  logic [3:0]              iDrainCycles,
  input  logic                    iStart,
  input  logic                    iDataValid,
  output logic                    oDataReady,
  input  logic [8*ARRAY_NUM-1:0]  iData1,
  input  logic [8*ARRAY_NUM-1:0]  iData2,
  input  logic [8*CUBE_NUM-1:0]   iWeight,
  output logic [8*ARRAY_NUM-1:0]  oData1,
  output logic [8*ARRAY_NUM-1:0]  oData2,
  output logic [8*CUBE_NUM-1:0]   oWeight,
  output logic [3*ARRAY_NUM-1:0]  oInputPattern,
  output logic [ARRAY_NUM-2:0]    oPassDataLeft,
  output logic                    oClearAcc,
  output logic                    oBusy,
  output logic                    oDone
`ifdef PE_CUBE_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]             oStallCnt
`endif
);

  localparam int PW = 3*ARRAY_NUM;
  localparam int GW = 4*ARRAY_NUM-1;
  localparam int DW = 8*ARRAY_NUM;
  localparam int WW = 8*CUBE_NUM;
  localparam logic [PW-1:0] c_not_care = {ARRAY_NUM{3'd5}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   step_q, step_d;
  logic [7:0]      blk_q, blk_d;
  logic [AW:0]     nsteps_q, nsteps_d;
  logic [7:0]      nblk_q, nblk_d;
  logic [AW-1:0]   clr_step_q, clr_step_d;
  logic [3:0]      drain_q, drain_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic            done_q, done_d;
  logic            clear_q, clear_d;
  logic [DW-1:0]   data1_q, data1_d;
  logic [DW-1:0]   data2_q, data2_d;
  logic [WW-1:0]   weight_q, weight_d;
  logic [PW-1:0]   pat_q, pat_d;
  logic [GW-PW-1:0] pass_q, pass_d;
  logic [GW-1:0]   prg_q [STEP_DEPTH];
  logic [GW-1:0]   prg_d [STEP_DEPTH];

  logic            w_start;
  logic            w_prg_we;
  logic            w_last_step;
  logic            w_last_blk;
  logic [GW-1:0]   w_entry;

  assign w_start     = (state_q == IDLE) && iStart && (iNumSteps != '0) && (iNumBlocks != '0);
  assign w_prg_we    = iPrgWe && (state_q == IDLE) && (int'(iPrgAddr) < STEP_DEPTH);
  assign w_last_step = ({1'b0, step_q} == (nsteps_q - 1'b1));
  assign w_last_blk  = (blk_q == (nblk_q - 8'd1));
  assign w_entry     = prg_q[step_q];

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    blk_d      = blk_q;
    nsteps_d   = nsteps_q;
    nblk_d     = nblk_q;
    clr_step_d = clr_step_q;
    drain_d    = drain_q;
    dcnt_d     = dcnt_q;
    done_d     = 1'b0;
    clear_d    = 1'b0;
    data1_d    = '0;
    data2_d    = '0;
    weight_d   = '0;
    pat_d      = c_not_care;
    pass_d     = '0;
    prg_d      = prg_q;
    if (w_prg_we) prg_d[iPrgAddr] = iPrgData;

    case (state_q)
      IDLE: begin
        if (w_start) begin
          state_d    = RUN;
          step_d     = '0;
          blk_d      = '0;
          nsteps_d   = iNumSteps;
          nblk_d     = iNumBlocks;
          clr_step_d = iClearStep;
          drain_d    = iDrainCycles;
        end
      end
      RUN: begin
        if (iDataValid) begin
          data1_d  = iData1;
          data2_d  = iData2;
          weight_d = iWeight;
          pat_d    = w_entry[PW-1:0];
          pass_d   = w_entry[GW-1:PW];
          // A clear step beyond the block length never matches step_q.
          clear_d  = (step_q == clr_step_q);
          if (w_last_step) begin
            step_d = '0;
            blk_d  = blk_q + 8'd1;
            if (w_last_blk) begin
              if (drain_q == 4'd0) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = DRAIN;
                dcnt_d  = drain_q;
              end
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= IDLE;
      step_q     <= '0;
      blk_q      <= '0;
      nsteps_q   <= '0;
      nblk_q     <= '0;
      clr_step_q <= '0;
      drain_q    <= '0;
      dcnt_q     <= '0;
      done_q     <= 1'b0;
      clear_q    <= 1'b0;
      data1_q    <= '0;
      data2_q    <= '0;
      weight_q   <= '0;
      pat_q      <= c_not_care;
      pass_q     <= '0;
      for (int i = 0; i < STEP_DEPTH; i++) prg_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      blk_q      <= blk_d;
      nsteps_q   <= nsteps_d;
      nblk_q     <= nblk_d;
      clr_step_q <= clr_step_d;
      drain_q    <= drain_d;
      dcnt_q     <= dcnt_d;
      done_q     <= done_d;
      clear_q    <= clear_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      weight_q   <= weight_d;
      pat_q      <= pat_d;
      pass_q     <= pass_d;
      prg_q      <= prg_d;
    end
  end

`ifdef PE_CUBE_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (w_start) begin
      stall_d = '0;
    end else if ((state_q == RUN) && !iDataValid && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign oStallCnt = stall_q;
`endif

  assign oDataReady    = (state_q == RUN);
  assign oBusy         = (state_q != IDLE);
  assign oDone         = done_q;
  assign oClearAcc     = clear_q;
  assign oData1        = data1_q;
  assign oData2        = data2_q;
  assign oWeight       = weight_q;
  assign oInputPattern = pat_q;
  assign oPassDataLeft = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_cube_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pe_cube_seq
// Brief   : Self-checking bench for pe_cube_seq against a run-level model.
// Revision: 1.0
// ============================================================================
module tb_pe_cube_seq;

  localparam int AN = 3;
  localparam int CN = 3;
  localparam int SD = 32;
  localparam int AW = 5;
  localparam logic [8:0] NOT_CARE = 9'h16D;

  logic          iClk = 1'b0;
  logic          iRstN = 1'b0;
  logic          iPrgWe;
  logic [AW-1:0] iPrgAddr;
  logic [10:0]   iPrgData;
  logic [AW:0]   iNumSteps;
  logic [7:0]    iNumBlocks;
  logic [AW-1:0] iClearStep;
  logic [3:0]    iDrainCycles;
  logic          iStart;
  logic          iDataValid;
  logic          oDataReady;
  logic [23:0]   iData1, iData2, iWeight;
  logic [23:0]   oData1, oData2, oWeight;
  logic [8:0]    oInputPattern;
  logic [1:0]    oPassDataLeft;
  logic          oClearAcc, oBusy, oDone;
`ifdef PE_CUBE_SEQ_STALL_CNT_EN
  logic [15:0]   oStallCnt;
`endif

  always #5 iClk = ~iClk;

  pe_cube_seq #(.ARRAY_NUM(AN), .CUBE_NUM(CN), .STEP_DEPTH(SD)) dut (
    .iClk(iClk), .iRstN(iRstN), .iPrgWe(iPrgWe), .iPrgAddr(iPrgAddr),
    .iPrgData(iPrgData), .iNumSteps(iNumSteps), .iNumBlocks(iNumBlocks),
    .iClearStep(iClearStep), .iDrainCycles(iDrainCycles), .iStart(iStart),
    .iDataValid(iDataValid), .oDataReady(oDataReady), .iData1(iData1),
    .iData2(iData2), .iWeight(iWeight), .oData1(oData1), .oData2(oData2),
    .oWeight(oWeight), .oInputPattern(oInputPattern),
    .oPassDataLeft(oPassDataLeft), .oClearAcc(oClearAcc), .oBusy(oBusy),
    .oDone(oDone)
`ifdef PE_CUBE_SEQ_STALL_CNT_EN
    , .oStallCnt(oStallCnt)
`endif
  );

  // Run-level model: program image, latched run config, accepted-step count.
  logic [10:0] prg_m [SD];
  int m_ph;      // 0 idle, 1 accepting steps, 2 draining
  int m_ns, m_nb, m_clr, m_dr, m_k, m_left, m_stall;
  int n_err, n_chk;
  int clr_obs, clr_pos, done_obs, out_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_d1"}, 32'(oData1), 32'd0);
    chk({tag, "_d2"}, 32'(oData2), 32'd0);
    chk({tag, "_w"}, 32'(oWeight), 32'd0);
    chk({tag, "_pat"}, 32'(oInputPattern), 32'(NOT_CARE));
    chk({tag, "_pass"}, 32'(oPassDataLeft), 32'd0);
    chk({tag, "_clr"}, 32'(oClearAcc), 32'd0);
    chk({tag, "_busy"}, 32'(oBusy), 32'd0);
    chk({tag, "_done"}, 32'(oDone), 32'd0);
    chk({tag, "_rdy"}, 32'(oDataReady), 32'd0);
`ifdef PE_CUBE_SEQ_STALL_CNT_EN
    chk({tag, "_stall"}, 32'(oStallCnt), 32'd0);
`endif
  endtask

  task automatic cycle(input bit v);
    logic [23:0] d1, d2, w;
    logic [23:0] e_d1, e_d2, e_w;
    logic [8:0]  e_pat;
    logic [1:0]  e_pass;
    logic [10:0] ent;
    bit e_clr, e_done, acc;
    int s;
    d1 = 24'($urandom); d2 = 24'($urandom); w = 24'($urandom);
    iDataValid = v; iData1 = d1; iData2 = d2; iWeight = w;
    e_d1 = '0; e_d2 = '0; e_w = '0; e_pat = NOT_CARE; e_pass = '0;
    e_clr = 1'b0; e_done = 1'b0; acc = 1'b0;
    if (m_ph == 0 && iPrgWe && int'(iPrgAddr) < SD) prg_m[iPrgAddr] = iPrgData;
    case (m_ph)
      0: if (iStart && iNumSteps != 0 && iNumBlocks != 0) begin
        m_ph = 1; m_ns = int'(iNumSteps); m_nb = int'(iNumBlocks);
        m_clr = int'(iClearStep); m_dr = int'(iDrainCycles);
        m_k = 0; m_stall = 0; clr_obs = 0; done_obs = 0; out_idx = 0; clr_pos = -1;
      end
      1: if (v) begin
        s = m_k % m_ns;
        ent = prg_m[s];
        acc = 1'b1;
        e_d1 = d1; e_d2 = d2; e_w = w;
        e_pat = ent[8:0]; e_pass = ent[10:9];
        e_clr = (s == m_clr);
        m_k++;
        if (m_k == m_ns * m_nb) begin
          if (m_dr == 0) begin m_ph = 0; e_done = 1'b1; end
          else begin m_ph = 2; m_left = m_dr; end
        end
      end else if (m_stall < 65535) begin
        m_stall++;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_ph = 0; e_done = 1'b1; end
      end
    endcase
    @(posedge iClk); #1;
    iStart = 1'b0; iPrgWe = 1'b0;
    if (acc) out_idx++;
    if (oClearAcc === 1'b1) begin clr_obs++; clr_pos = out_idx; end
    if (oDone === 1'b1) done_obs++;
    chk("d1", 32'(oData1), 32'(e_d1));
    chk("d2", 32'(oData2), 32'(e_d2));
    chk("w", 32'(oWeight), 32'(e_w));
    chk("pat", 32'(oInputPattern), 32'(e_pat));
    chk("pass", 32'(oPassDataLeft), 32'(e_pass));
    chk("clr", 32'(oClearAcc), 32'(e_clr));
    chk("done", 32'(oDone), 32'(e_done));
    chk("busy", 32'(oBusy), 32'(m_ph != 0));
    chk("rdy", 32'(oDataReady), 32'(m_ph == 1));
`ifdef PE_CUBE_SEQ_STALL_CNT_EN
    chk("stall", 32'(oStallCnt), 32'(m_stall));
`endif
  endtask

  task automatic start_run(input int ns, input int nb, input int clr, input int dr);
    iNumSteps = (AW+1)'(ns); iNumBlocks = 8'(nb);
    iClearStep = AW'(clr); iDrainCycles = 4'(dr);
    iStart = 1'b1;
    cycle(1'b0);
  endtask

  // Runs until the model is idle; scrambles config, start and program
  // inputs while busy, all of which must be ignored.
  task automatic run_to_idle(input int stall_at, input int stall_len, input int valid_pct);
    int guard, st;
    bit v;
    guard = 0; st = 0;
    while (m_ph != 0 && guard < 3000) begin
      iNumSteps = (AW+1)'($urandom); iNumBlocks = 8'($urandom);
      iClearStep = AW'($urandom); iDrainCycles = 4'($urandom);
      iStart = ($urandom_range(0, 7) == 0);
      iPrgWe = ($urandom_range(0, 3) == 0);
      iPrgAddr = AW'($urandom); iPrgData = 11'($urandom);
      v = ($urandom_range(1, 100) <= valid_pct);
      if (m_ph == 1 && stall_at >= 0 && m_k == stall_at && st < stall_len) begin
        v = 1'b0; st++;
      end
      cycle(v);
      guard++;
    end
    if (guard >= 3000) begin
      n_chk++; n_err++;
      $error("FAIL run_timeout: observed busy expected idle");
    end
    chk("run_done_cnt", 32'(done_obs), 32'd1);
    chk("run_clr_cnt", 32'(clr_obs), 32'((m_clr < m_ns) ? m_nb : 0));
    chk("run_steps", 32'(out_idx), 32'(m_ns * m_nb));
  endtask

  initial begin
    n_err = 0; n_chk = 0; m_ph = 0; m_stall = 0;
    clr_obs = 0; clr_pos = -1; done_obs = 0; out_idx = 0;
    m_ns = 1; m_nb = 1; m_clr = 0; m_dr = 0; m_k = 0; m_left = 0;
    for (int i = 0; i < SD; i++) prg_m[i] = '0;
    iPrgWe = 0; iPrgAddr = '0; iPrgData = '0; iNumSteps = '0; iNumBlocks = '0;
    iClearStep = '0; iDrainCycles = '0; iStart = 0; iDataValid = 0;
    iData1 = '0; iData2 = '0; iWeight = '0;

    #12;
    check_reset("por");
    @(negedge iClk); iRstN = 1'b1;
    cycle(1'b0);

    for (int a = 0; a < SD; a++) begin
      iPrgWe = 1'b1; iPrgAddr = AW'(a); iPrgData = 11'($urandom);
      cycle(1'b0);
    end

    // Single block, clear on step 27, drain of 4.
    start_run(31, 1, 27, 4);
    run_to_idle(-1, 0, 100);
    chk("one_blk_clr_pos", 32'(clr_pos), 32'd28);

    // Three blocks: last clear lands on output 28 + 2*31.
    start_run(31, 3, 27, 4);
    run_to_idle(-1, 0, 100);
    chk("three_blk_clr_pos", 32'(clr_pos), 32'd90);

    // Two-cycle stall ahead of step 10.
    start_run(31, 1, 27, 2);
    run_to_idle(10, 2, 100);
`ifdef PE_CUBE_SEQ_STALL_CNT_EN
    chk("stall_two", 32'(oStallCnt), 32'd2);
`endif

    // Degenerate starts are ignored.
    iNumSteps = '0; iNumBlocks = 8'd1; iStart = 1'b1;
    cycle(1'b0);
    chk("zero_steps_busy", 32'(oBusy), 32'd0);
    iNumSteps = 6'd6; iNumBlocks = 8'd0; iStart = 1'b1;
    cycle(1'b0);
    chk("zero_blocks_busy", 32'(oBusy), 32'd0);

    // Write to entry 5 while running must not land.
    start_run(8, 1, 3, 1);
    cycle(1'b1);
    iPrgWe = 1'b1; iPrgAddr = 5'd5; iPrgData = '0;
    cycle(1'b1);
    run_to_idle(-1, 0, 100);
    start_run(8, 1, 31, 0);
    run_to_idle(-1, 0, 100);

    // Randomized runs with intermittent valid.
    for (int r = 0; r < 4; r++) begin
      start_run($urandom_range(1, 32), $urandom_range(1, 3),
                $urandom_range(0, 31), $urandom_range(0, 15));
      run_to_idle(-1, 0, 70);
    end

    // Asynchronous reset at step 15 of block 1.
    start_run(31, 2, 27, 3);
    while (m_k < 46) cycle(1'b1);
    #2 iRstN = 1'b0;
    #1;
    check_reset("mid_rst");
    m_ph = 0; m_stall = 0; done_obs = 0;
    for (int i = 0; i < SD; i++) prg_m[i] = '0;
    @(posedge iClk); @(posedge iClk);
    @(negedge iClk); iRstN = 1'b1;
    cycle(1'b0);
    chk("post_rst_no_done", 32'(done_obs), 32'd0);

    // Program image was cleared by reset; new run starts at step 0.
    start_run(4, 1, 2, 0);
    run_to_idle(-1, 0, 100);
    chk("post_rst_clr_pos", 32'(clr_pos), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
